spi_frame_master: RTL

Host-side serial frame generator that drives the SPI slave/RAM subsystem through its MOSI, SS_n and MISO pins. It converts a parallel host request (2-bit command plus 8-bit payload) into one serial frame. For read-data commands it also captures the 8-bit reply shifted back on MISO. One serial bit moves per clk cycle, and there is no separate SCLK: the slave samples on the shared clk.

---
 rtl/spi_frame_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_frame_master.sv
// Serial frame master: sends a {cmd, payload} frame MSB first on MOSI, one bit per clk,
// and for read-data frames captures an 8-bit MISO reply after RD_WAIT turnaround cycles.
module spi_frame_master #(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SS_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(9);
  localparam logic [CW-1:0] READ_LOAD  = CW'(7);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
  localparam logic [1:0]    CMD_RDATA  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SHIFT, S_WAIT, S_READ, S_END
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q;
  logic [7:0]    data_q;
  logic [7:0]    sreg_q;
  logic [9:0]    frame;
  logic          mosi_d, ss_d, busy_d, done_d;

  assign frame = {cmd_q, data_q};

  // State, counter, request latch, capture shifter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      sreg_q  <= '0;
      rdata   <= '0;
      MOSI    <= 1'b0;
      SS_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && start) begin
        cmd_q  <= cmd;
        data_q <= wdata;
      end
      if (state_q == S_READ) sreg_q <= {sreg_q[6:0], MISO};
      if (state_q == S_END && cmd_q == CMD_RDATA) rdata <= sreg_q;
      MOSI <= mosi_d;
      SS_n <= ss_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Next state and bit/wait/read counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CMD;
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = SHIFT_LOAD;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (cmd_q != CMD_RDATA) begin
          state_d = S_END;
        end else if (RD_WAIT == 0) begin
          state_d = S_READ;
          cnt_d   = READ_LOAD;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_READ;
          cnt_d   = READ_LOAD;
        end
      end
      S_READ: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = S_END;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the current state; registered one edge later
  always_comb begin
    mosi_d = 1'b0;
    ss_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      S_CMD: begin
        ss_d   = 1'b0;
        busy_d = 1'b1;
        mosi_d = cmd_q[1];
      end
      S_SHIFT: begin
        ss_d   = 1'b0;
        busy_d = 1'b1;
        mosi_d = frame[cnt_q];
      end
      S_WAIT, S_READ: begin
        ss_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_END: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
